spi_frame_tx: RTL
=================

# spi_frame_tx

Serializing master for the matrix-driver SPI link. Accepts a parallel command/data frame on a valid/ready handshake and shifts it MSB-first onto sck/sdi, framed by an active-high cen. The bit-level format is exactly what displaydriver consumes on its sck/sdi/cen inputs. Optionally holds off the next frame until the driver reports done, so frames never overrun a display write in progress.

## Interface
- N, 16, frame width in bits (≥2)
- HALF, 1, sck half-period in clk cycles (≥1)
- GAP, 2, minimum cen-low cycles between frames (≥1)
- WAIT_DONE, 1, when 1 wait for drv_done after each frame
- TIMEOUT, 4096, max cycles to wait for drv_done (≥1)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- frame  in  N  frame to send, bit N-1 first
- valid  in  1  frame is valid
- ready  out  1  block can accept a frame
- drv_done  in  1  level done from displaydriver
- sck  out  1  serial clock to driver
- sdi  out  1  serial data to driver
- cen  out  1  frame enable, high for the whole frame
- tx_done  out  1  one-cycle pulse, frame fully shifted
- timeout  out  1  one-cycle pulse, drv_done never arrived

## Operation
- States: IDLE, SHIFT, GAP, WAIT.
- IDLE: ready=1, cen=0, sck=0, sdi=0. On valid&&ready, latch frame into shift register, bit counter=0, phase counter=0, go SHIFT.
- SHIFT: cen=1, sdi=shreg[N-1]. Each bit is sck low for HALF cycles, then sck high for HALF cycles. On the high→low transition, shift left and increment the bit counter. After the high phase of bit N-1, go GAP, assert tx_done for that one cycle, and drive cen=0, sck=0, sdi=0.
- GAP: count GAP cycles with cen=0. Then go WAIT if WAIT_DONE=1, else go IDLE.
- WAIT: count up to TIMEOUT.
  - drv_done=1 sampled → IDLE.
  - TIMEOUT cycles elapse without drv_done → pulse timeout one cycle, go IDLE.
- ready=1 only in IDLE. valid outside IDLE is ignored and is not queued. The frame input is don't-care after acceptance.
- drv_done is ignored outside WAIT. A done level that is already high on entry to WAIT satisfies it immediately.
- tx_done and timeout never assert in the same cycle.

## Timing
- Reset values: ready=1 (the cycle after reset deasserts), sck=0, sdi=0, cen=0, tx_done=0, timeout=0. State IDLE, all counters 0.
- Accept at edge k. From cycle k+1: cen=1, sdi=frame[N-1], sck=0.
- sck first rises at cycle k+1+HALF.
- sdi changes only while sck=0, at least HALF cycles before the next rising sck edge, and is stable through the high phase.
- cen-high duration is exactly 2·N·HALF cycles. It covers N rising sck edges.
- tx_done is high in cycle k+1+2·N·HALF, the first cen-low cycle.
- WAIT_DONE=0: ready returns at cycle k+1+2·N·HALF+GAP. The next cen can rise one cycle after the next accept, so the minimum cen-low gap is GAP+1 cycles.
- WAIT_DONE=1: ready returns the cycle after drv_done is sampled in WAIT, or the cycle after the timeout pulse.
- Reset mid-operation, any state: the next cycle shows the reset values. The in-flight frame is discarded, and tx_done/timeout do not pulse.
- Counters are sized for their parameter maxima. The phase counter wraps at HALF-1 and the bit counter stops at N-1. There is no wraparound into a second frame.

## Test plan
- N=16, HALF=1, WAIT_DONE=0, frame=16'h8080 → cen high 32 cycles; sdi sampled on sck rising edges reads 1,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0; tx_done at cycle k+33; ready again at k+35.
- HALF=3, frame=16'hA5C3 → each sck level lasts 3 cycles, cen high 96 cycles; sdi is constant during every sck-high phase and the bits reconstruct to 16'hA5C3.
- valid held high with two frames back-to-back (16'h1234 then 16'hFFFF), WAIT_DONE=0, GAP=2 → second cen rises exactly 3 cycles after the first cen falls; changes to frame during SHIFT have no effect.
- WAIT_DONE=1, drv_done raised 50 cycles after tx_done → ready stays 0 until the cycle after drv_done is sampled; no timeout pulse.
- WAIT_DONE=1, TIMEOUT=100, drv_done held 0 → timeout pulses once, exactly 100 cycles after WAIT is entered; ready=1 next cycle.
- reset asserted at the 7th sck rising edge of a frame → next cycle cen=0, sck=0, sdi=0, ready=1, and tx_done is never pulsed; a new frame then sends correctly.

Source files
------------

// File: rtl/spi_frame_tx.sv
// SPI frame serializer for the matrix-driver link: shifts a parallel frame MSB-first
// on sck/sdi framed by cen, then optionally waits for the driver's done level.
module spi_frame_tx #(
   parameter int N         = 16,
   parameter int HALF      = 1,
   parameter int GAP       = 2,
   parameter int WAIT_DONE = 1,
   parameter int TIMEOUT   = 4096
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] frame,
   input  logic         valid,
   output logic         ready,
   input  logic         drv_done,
   output logic         sck,
   output logic         sdi,
   output logic         cen,
   output logic         tx_done,
   output logic         timeout
);

   localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int BW = $clog2(N);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_GAP,
      S_WAIT
   } state_t;

   state_t        state, state_n;
   logic [N-1:0]  shreg, shreg_n;
   logic [PW-1:0] phase, phase_n;
   logic          sckhi, sckhi_n;
   logic [BW-1:0] bitcnt, bitcnt_n;
   logic [GW-1:0] gapcnt, gapcnt_n;
   logic [TW-1:0] waitcnt, waitcnt_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         shreg   <= '0;
         phase   <= '0;
         sckhi   <= 1'b0;
         bitcnt  <= '0;
         gapcnt  <= '0;
         waitcnt <= '0;
      end else begin
         state   <= state_n;
         shreg   <= shreg_n;
         phase   <= phase_n;
         sckhi   <= sckhi_n;
         bitcnt  <= bitcnt_n;
         gapcnt  <= gapcnt_n;
         waitcnt <= waitcnt_n;
      end
   end

   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      phase_n   = phase;
      sckhi_n   = sckhi;
      bitcnt_n  = bitcnt;
      gapcnt_n  = gapcnt;
      waitcnt_n = waitcnt;
      ready     = 1'b0;
      cen       = 1'b0;
      sck       = 1'b0;
      sdi       = 1'b0;
      tx_done   = 1'b0;
      timeout   = 1'b0;
      case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (valid) begin
               shreg_n  = frame;
               phase_n  = '0;
               sckhi_n  = 1'b0;
               bitcnt_n = '0;
               state_n  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            cen = 1'b1;
            sck = sckhi;
            sdi = shreg[N-1];
            if (phase != PW'(HALF - 1)) begin
               phase_n = phase + PW'(1);
            end else begin
               phase_n = '0;
               if (!sckhi) begin
                  sckhi_n = 1'b1;
               end else begin
                  // data only moves on the falling sck edge, keeping sdi stable while high
                  sckhi_n = 1'b0;
                  if (bitcnt == BW'(N - 1)) begin
                     gapcnt_n = '0;
                     state_n  = S_GAP;
                  end else begin
                     shreg_n  = {shreg[N-2:0], 1'b0};
                     bitcnt_n = bitcnt + BW'(1);
                  end
               end
            end
         end
         S_GAP: begin
            tx_done = (gapcnt == '0);
            if (gapcnt == GW'(GAP - 1)) begin
               waitcnt_n = '0;
               state_n   = (WAIT_DONE != 0) ? S_WAIT : S_IDLE;
            end else begin
               gapcnt_n = gapcnt + GW'(1);
            end
         end
         S_WAIT: begin
            // done wins over an expiring timeout in the same cycle
            if (drv_done) begin
               state_n = S_IDLE;
            end else if (waitcnt == TW'(TIMEOUT)) begin
               timeout = 1'b1;
               state_n = S_IDLE;
            end else begin
               waitcnt_n = waitcnt + TW'(1);
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule
